// File: rtl/bcd_down_counter_if.sv
// Control/data bundle for bcd_down_counter: enable, load, value, count, TC, BO.
// The master drives EC/LD/D; the counter (slave) returns Q/TC/BO.
interface bcd_down_counter_if #(
    parameter int DIGITS = 2
);
    logic                  EC;
    logic                  LD;
    logic [4*DIGITS-1:0]   D;
    logic [4*DIGITS-1:0]   Q;
    logic                  TC;
    logic                  BO;

    modport master (
        output EC,
        output LD,
        output D,
        input  Q,
        input  TC,
        input  BO
    );

    modport slave (
        input  EC,
        input  LD,
        input  D,
        output Q,
        output TC,
        output BO
    );
endinterface

// File: rtl/bcd_down_counter.sv
// Cascadable BCD down-counter with clamped parallel load, TC and borrow out.
// Define BCD_DOWN_COUNTER_SATURATE_EN to stop at zero instead of wrapping.
module bcd_down_counter #(
    parameter int DIGITS = 2
) (
    input  logic              clk,
    input  logic              r,
    bcd_down_counter_if.slave bus
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]    q_r;
    logic [W-1:0]    q_ld;
    logic [W-1:0]    q_dec;
    logic [W-1:0]    q_cnt;
    logic [DIGITS:0] brw;
    logic            tc;

    assign tc = (q_r == '0);

    // brw[k]: every digit below k is zero, so digit k steps this count
    always_comb begin
        q_ld   = '0;
        q_dec  = '0;
        brw    = '0;
        brw[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (bus.D[4*k +: 4] > 4'd9)
                q_ld[4*k +: 4] = 4'd9;
            else
                q_ld[4*k +: 4] = bus.D[4*k +: 4];

            if (!brw[k])
                q_dec[4*k +: 4] = q_r[4*k +: 4];
            else if (q_r[4*k +: 4] == 4'd0)
                q_dec[4*k +: 4] = 4'd9;
            else
                q_dec[4*k +: 4] = q_r[4*k +: 4] - 4'd1;

            brw[k+1] = brw[k] & (q_r[4*k +: 4] == 4'd0);
        end
    end

`ifdef BCD_DOWN_COUNTER_SATURATE_EN
    assign q_cnt = tc ? q_r : q_dec;
`else
    assign q_cnt = q_dec;
`endif

    always_ff @(posedge clk) begin
        priority case (1'b1)
            r:       q_r <= {DIGITS{4'h9}};
            bus.LD:  q_r <= q_ld;
            bus.EC:  q_r <= q_cnt;
            default: q_r <= q_r;
        endcase
    end

    assign bus.Q  = q_r;
    assign bus.TC = tc;
    assign bus.BO = tc & bus.EC & ~bus.LD;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench: DIGITS=2 counter plus a two-stage DIGITS=1 cascade.
module tb_bcd_down_counter;

    typedef struct packed {
        logic [7:0] q;
        logic       tc;
        logic       bo;
    } exp_t;

    logic clk = 1'b0;
    logic r;
    int   n_cmp = 0;
    int   n_err = 0;
    int   mq;
    exp_t sbq[$];

    always #5 clk = ~clk;

    bcd_down_counter_if #(.DIGITS(2)) m_if ();
    bcd_down_counter_if #(.DIGITS(1)) lo_if ();
    bcd_down_counter_if #(.DIGITS(1)) hi_if ();

    assign hi_if.EC = lo_if.BO;

    bcd_down_counter #(.DIGITS(2)) dut (
        .clk (clk),
        .r   (r),
        .bus (m_if)
    );

    bcd_down_counter #(.DIGITS(1)) c_lo (
        .clk (clk),
        .r   (r),
        .bus (lo_if)
    );

    bcd_down_counter #(.DIGITS(1)) c_hi (
        .clk (clk),
        .r   (r),
        .bus (hi_if)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Drive one cycle of stimulus and queue the value expected after the edge
    task automatic drive(input logic rr, input logic ld, input logic ec,
                         input logic [7:0] d);
        exp_t e;
        int   t;
        int   u;
        @(negedge clk);
        r        = rr;
        m_if.LD  = ld;
        m_if.EC  = ec;
        m_if.D   = d;
        lo_if.LD = ld;
        lo_if.EC = ec;
        lo_if.D  = d[3:0];
        hi_if.LD = ld;
        hi_if.D  = d[7:4];
        if (rr) begin
            mq = 99;
        end else if (ld) begin
            t  = (d[7:4] > 4'd9) ? 9 : int'(d[7:4]);
            u  = (d[3:0] > 4'd9) ? 9 : int'(d[3:0]);
            mq = t * 10 + u;
        end else if (ec) begin
`ifdef BCD_DOWN_COUNTER_SATURATE_EN
            mq = (mq == 0) ? 0 : mq - 1;
`else
            mq = (mq == 0) ? 99 : mq - 1;
`endif
        end
        e.q  = to_bcd(mq);
        e.tc = (mq == 0);
        e.bo = e.tc & ec & ~ld;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1'b1, 1'b1, 1'b0, 8'h12);
        @(posedge clk); #1;
        e = sbq.pop_front();
        n_cmp++;
        if (m_if.Q !== 8'h99 || m_if.TC !== 1'b0 || m_if.BO !== 1'b0
            || e.q !== 8'h99) begin
            n_err++;
            $display("FAIL reset: Q=%h TC=%b BO=%b expected Q=99 TC=0 BO=0",
                     m_if.Q, m_if.TC, m_if.BO);
        end
    endtask

    task automatic test_countdown();
        exp_t e;
        for (int i = 1; i <= 100; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if ({m_if.Q, m_if.TC, m_if.BO} !== {e.q, e.tc, e.bo}) begin
                n_err++;
                $display("FAIL countdown[%0d]: Q=%h TC=%b BO=%b expected Q=%h TC=%b BO=%b",
                         i, m_if.Q, m_if.TC, m_if.BO, e.q, e.tc, e.bo);
            end
        end
    endtask

    task automatic test_load();
        exp_t e;
        logic [7:0] d_tab [5] = '{8'h45, 8'h00, 8'h3C, 8'hF7, 8'hAA};
        logic       l_tab [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, l_tab[i], 1'b1, d_tab[i]);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if ({m_if.Q, m_if.TC, m_if.BO} !== {e.q, e.tc, e.bo}) begin
                n_err++;
                $display("FAIL load[%0d]: Q=%h TC=%b BO=%b expected Q=%h TC=%b BO=%b",
                         i, m_if.Q, m_if.TC, m_if.BO, e.q, e.tc, e.bo);
            end
        end
        // Load while at zero: TC high but the load suppresses BO
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        e = sbq.pop_front();
        drive(1'b0, 1'b1, 1'b1, 8'h55);
        #1;
        n_cmp++;
        if (m_if.TC !== 1'b1 || m_if.BO !== 1'b0) begin
            n_err++;
            $display("FAIL load_at_zero: TC=%b BO=%b expected TC=1 BO=0",
                     m_if.TC, m_if.BO);
        end
        @(posedge clk); #1;
        e = sbq.pop_front();
        n_cmp++;
        if (m_if.Q !== e.q || m_if.BO !== e.bo) begin
            n_err++;
            $display("FAIL load_55: Q=%h BO=%b expected Q=%h BO=%b",
                     m_if.Q, m_if.BO, e.q, e.bo);
        end
    endtask

    task automatic test_borrow_hold();
        exp_t e;
        logic l_tab [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic c_tab [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, l_tab[i], c_tab[i], 8'h10);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if ({m_if.Q, m_if.TC, m_if.BO} !== {e.q, e.tc, e.bo}) begin
                n_err++;
                $display("FAIL borrow_hold[%0d]: Q=%h TC=%b BO=%b expected Q=%h TC=%b BO=%b",
                         i, m_if.Q, m_if.TC, m_if.BO, e.q, e.tc, e.bo);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic r_tab [3] = '{1'b0, 1'b0, 1'b1};
        logic l_tab [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(r_tab[i], l_tab[i], 1'b1, 8'h01);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if ({m_if.Q, m_if.TC, m_if.BO} !== {e.q, e.tc, e.bo}) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: Q=%h TC=%b BO=%b expected Q=%h TC=%b BO=%b",
                         i, m_if.Q, m_if.TC, m_if.BO, e.q, e.tc, e.bo);
            end
        end
    endtask

    task automatic test_cascade();
        exp_t e;
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        e = sbq.pop_front();
        for (int i = 1; i <= 100; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if (m_if.Q !== e.q
`ifndef BCD_DOWN_COUNTER_SATURATE_EN
                || {hi_if.Q, lo_if.Q} !== e.q
                || (hi_if.TC & lo_if.TC) !== e.tc
`endif
               ) begin
                n_err++;
                $display("FAIL cascade[%0d]: chain=%h single=%h expected %h",
                         i, {hi_if.Q, lo_if.Q}, m_if.Q, e.q);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 3) != 0),
                  8'($urandom_range(0, 255)));
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_cmp++;
            if ({m_if.Q, m_if.TC, m_if.BO} !== {e.q, e.tc, e.bo}) begin
                n_err++;
                $display("FAIL random[%0d]: Q=%h TC=%b BO=%b expected Q=%h TC=%b BO=%b",
                         i, m_if.Q, m_if.TC, m_if.BO, e.q, e.tc, e.bo);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        r        = 1'b1;
        m_if.LD  = 1'b0;
        m_if.EC  = 1'b0;
        m_if.D   = '0;
        lo_if.LD = 1'b0;
        lo_if.EC = 1'b0;
        lo_if.D  = '0;
        hi_if.LD = 1'b0;
        hi_if.D  = '0;
        mq       = 99;
        test_reset();
        test_countdown();
        test_load();
        test_borrow_hold();
        test_reset_mid();
        test_cascade();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
